// File: rtl/cadr_ddram_pkg.sv
// Shared types and helpers for the CADR DDRAM arbiter.
// No ports; package only.
// Holds the FSM state encoding, byte-enable constants and beat address math.
package cadr_ddram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        ACK     = 2'd3
    } state_t;

    localparam logic [7:0] BE_LO = 8'h0F;
    localparam logic [7:0] BE_HI = 8'hF0;

    // Two 32-bit client words share one 64-bit beat; the sum wraps modulo 2^29.
    function automatic logic [28:0] beat_addr(input logic [28:0] base,
                                              input logic [31:0] waddr);
        beat_addr = base + 29'(waddr >> 1);
    endfunction

endpackage

// File: rtl/cadr_rr_arbiter.sv
// Round-robin request picker: first requester after i_last, wrapping modulo N.
// Purely combinational, zero latency.
// Ports: i_req (requests), i_last (previous grant), o_grant (one-hot), o_idx, o_any.
module cadr_rr_arbiter #(
    parameter int N  = 2,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [LW-1:0] i_last,
    output logic [N-1:0]  o_grant,
    output logic [LW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        // Scan starting just past the last grant so the previous winner is checked last.
        for (int k = 1; k <= N; k++) begin
            j = (int'(i_last) + k) % N;
            if (!o_any && i_req[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = LW'(j);
            end
        end
    end

endmodule

// File: rtl/cadr_ddram_arbiter.sv
// Shares the DDRAM Avalon port among NCLIENT 32-bit clients, round-robin, one single-beat access at a time.
// Latency: write req->ack 3 cycles, read 3 cycles + DDRAM read latency (line-buffer hit 2 cycles).
// Backpressure: DDRAM_BUSY holds the command stable; clients hold cl_req until cl_ack.
// Ports: clk_sys/reset (sync, active-high); cl_* client request/ack buses; busy; DDRAM_* Avalon pins.
// Optional macro CADR_DDRAM_LINEBUF_EN adds a one-beat read buffer per client.
module cadr_ddram_arbiter
    import cadr_ddram_pkg::*;
#(
    parameter int          NCLIENT   = 2,
    parameter int          AW        = 22,
    parameter logic [28:0] BASE_ADDR = 29'h0600_0000
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [NCLIENT-1:0]    cl_req,
    input  logic [NCLIENT-1:0]    cl_we,
    input  logic [NCLIENT*AW-1:0] cl_addr,
    input  logic [NCLIENT*32-1:0] cl_wdata,
    output logic [NCLIENT*32-1:0] cl_rdata,
    output logic [NCLIENT-1:0]    cl_ack,
    output logic                  busy,
    input  logic                  DDRAM_BUSY,
    output logic [7:0]            DDRAM_BURSTCNT,
    output logic [28:0]           DDRAM_ADDR,
    input  logic [63:0]           DDRAM_DOUT,
    input  logic                  DDRAM_DOUT_READY,
    output logic                  DDRAM_RD,
    output logic [63:0]           DDRAM_DIN,
    output logic [7:0]            DDRAM_BE,
    output logic                  DDRAM_WE
);

    localparam int GW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;

    state_t                r_state, w_nxt;
    logic [GW-1:0]         r_last, r_gnt;
    logic                  r_we;
    logic [AW-1:0]         r_addr;
    logic                  r_rd, r_wr;
    logic [28:0]           r_ddr_addr;
    logic [7:0]            r_be;
    logic [63:0]           r_din;
    logic [NCLIENT*32-1:0] r_rdata;

    logic [NCLIENT-1:0]    w_grant;
    logic [GW-1:0]         w_idx;
    logic                  w_any;
    logic [AW-1:0]         w_req_addr;
    logic [31:0]           w_req_wdata;
    logic                  w_req_we;
    logic                  w_hit;
    logic [31:0]           w_hit_dat;

    cadr_rr_arbiter #(.N(NCLIENT), .LW(GW)) u_rr (
        .i_req   (cl_req),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_req_addr  = cl_addr[int'(w_idx)*AW +: AW];
    assign w_req_wdata = cl_wdata[int'(w_idx)*32 +: 32];
    assign w_req_we    = |(cl_we & w_grant);

`ifdef CADR_DDRAM_LINEBUF_EN
    logic [NCLIENT-1:0] r_lb_vld;
    logic [AW-2:0]      r_lb_tag [NCLIENT];
    logic [63:0]        r_lb_dat [NCLIENT];

    assign w_hit     = w_any && !w_req_we && r_lb_vld[w_idx] &&
                       (r_lb_tag[w_idx] == w_req_addr[AW-1:1]);
    assign w_hit_dat = w_req_addr[0] ? r_lb_dat[w_idx][63:32] : r_lb_dat[w_idx][31:0];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_lb_vld <= '0;
        end else begin
            // A granted write kills any buffered copy of that beat, in every client.
            if (r_state == IDLE && w_any && w_req_we) begin
                for (int i = 0; i < NCLIENT; i++) begin
                    if (r_lb_tag[i] == w_req_addr[AW-1:1]) r_lb_vld[i] <= 1'b0;
                end
            end
            if (r_state == WAIT_RD && DDRAM_DOUT_READY) begin
                r_lb_vld[r_gnt] <= 1'b1;
                r_lb_tag[r_gnt] <= r_addr[AW-1:1];
                r_lb_dat[r_gnt] <= DDRAM_DOUT;
            end
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_dat = '0;
`endif

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nxt;
    end

    // Next-state logic
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_nxt = w_hit ? ACK : ISSUE;
            ISSUE:   if (!DDRAM_BUSY) w_nxt = r_we ? ACK : WAIT_RD;
            WAIT_RD: if (DDRAM_DOUT_READY) w_nxt = ACK;
            ACK:     w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    // Datapath registers; command outputs are loaded at grant and held through ISSUE.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_last     <= GW'(NCLIENT - 1);
            r_gnt      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_ddr_addr <= '0;
            r_be       <= '0;
            r_din      <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt  <= w_idx;
                        r_last <= w_idx;
                        r_we   <= w_req_we;
                        r_addr <= w_req_addr;
                        if (w_hit) begin
                            r_rdata[int'(w_idx)*32 +: 32] <= w_hit_dat;
                        end else begin
                            r_rd       <= !w_req_we;
                            r_wr       <= w_req_we;
                            r_ddr_addr <= beat_addr(BASE_ADDR, 32'(w_req_addr));
                            r_be       <= w_req_addr[0] ? BE_HI : BE_LO;
                            r_din      <= {2{w_req_wdata}};
                        end
                    end
                end
                ISSUE: begin
                    if (!DDRAM_BUSY) begin
                        r_rd <= 1'b0;
                        r_wr <= 1'b0;
                    end
                end
                WAIT_RD: begin
                    if (DDRAM_DOUT_READY)
                        r_rdata[int'(r_gnt)*32 +: 32] <= r_addr[0] ? DDRAM_DOUT[63:32]
                                                                   : DDRAM_DOUT[31:0];
                end
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy = (r_state != IDLE);
        for (int i = 0; i < NCLIENT; i++)
            cl_ack[i] = (r_state == ACK) && (r_gnt == GW'(i));
    end

    assign cl_rdata       = r_rdata;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = r_ddr_addr;
    assign DDRAM_RD       = r_rd;
    assign DDRAM_WE       = r_wr;
    assign DDRAM_DIN      = r_din;
    assign DDRAM_BE       = r_be;

endmodule

// File: tb/tb_cadr_ddram_arbiter.sv
// Directed bench for cadr_ddram_arbiter with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
// Define CADR_DDRAM_LINEBUF_EN for both bench and RTL to cover the read buffer.
module tb_cadr_ddram_arbiter;
    localparam int NC = 2;
    localparam int AW = 22;

    logic              clk_sys = 1'b0;
    logic              reset   = 1'b1;
    logic [NC-1:0]     cl_req  = '0;
    logic [NC-1:0]     cl_we   = '0;
    logic [NC*AW-1:0]  cl_addr = '0;
    logic [NC*32-1:0]  cl_wdata = '0;
    logic [NC*32-1:0]  cl_rdata;
    logic [NC-1:0]     cl_ack;
    logic              busy;
    logic              DDRAM_BUSY = 1'b0;
    logic [7:0]        DDRAM_BURSTCNT;
    logic [28:0]       DDRAM_ADDR;
    logic [63:0]       DDRAM_DOUT = '0;
    logic              DDRAM_DOUT_READY = 1'b0;
    logic              DDRAM_RD;
    logic [63:0]       DDRAM_DIN;
    logic [7:0]        DDRAM_BE;
    logic              DDRAM_WE;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;

    always #5 clk_sys = ~clk_sys;

    cadr_ddram_arbiter #(.NCLIENT(NC), .AW(AW), .BASE_ADDR(29'h0600_0000)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .cl_req(cl_req), .cl_we(cl_we), .cl_addr(cl_addr), .cl_wdata(cl_wdata),
        .cl_rdata(cl_rdata), .cl_ack(cl_ack), .busy(busy),
        .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
        .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_RD(DDRAM_RD),
        .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
    );

    // Commands accepted by the DDRAM side (RD/WE high with waitrequest low).
    always @(posedge clk_sys)
        if (!reset && (DDRAM_RD || DDRAM_WE) && !DDRAM_BUSY) n_acc <= n_acc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk_sys);
    endtask

    task automatic set_cl(input int c, input logic req, input logic we,
                          input logic [AW-1:0] a, input logic [31:0] d);
        cl_req[c]            = req;
        cl_we[c]             = we;
        cl_addr[c*AW +: AW]  = a;
        cl_wdata[c*32 +: 32] = d;
    endtask

    initial begin
        int got;
        int a0;
        logic [1:0] exp_ack;

        // Reset state
        tick; tick;
        chk("rst_ack",   64'(cl_ack), 64'd0);
        chk("rst_rdata", 64'(cl_rdata), 64'd0);
        chk("rst_rd",    64'(DDRAM_RD), 64'd0);
        chk("rst_we",    64'(DDRAM_WE), 64'd0);
        chk("rst_addr",  64'(DDRAM_ADDR), 64'd0);
        chk("rst_be",    64'(DDRAM_BE), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("burstcnt",  64'(DDRAM_BURSTCNT), 64'd1);
        reset = 1'b0;
        tick;

        // 1: single write, client 0, odd word -> high half of beat 2
        set_cl(0, 1'b1, 1'b1, 22'h000005, 32'hDEADBEEF);
        tick;
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_we",   64'(DDRAM_WE), 64'd1);
        chk("t1_rd",   64'(DDRAM_RD), 64'd0);
        chk("t1_addr", 64'(DDRAM_ADDR), 64'h0600_0002);
        chk("t1_be",   64'(DDRAM_BE), 64'hF0);
        chk("t1_din",  DDRAM_DIN, 64'hDEADBEEF_DEADBEEF);
        chk("t1_ack_early", 64'(cl_ack), 64'd0);
        tick;
        chk("t1_ack",  64'(cl_ack), 64'b01);
        chk("t1_we_drop", 64'(DDRAM_WE), 64'd0);
        set_cl(0, 1'b0, 1'b0, 22'h0, 32'h0);
        tick;
        chk("t1_ack_1cyc", 64'(cl_ack), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);

        // 2: read back, DDRAM answers a few cycles after acceptance
        set_cl(0, 1'b1, 1'b0, 22'h000005, 32'h0);
        tick;
        chk("t2_rd",   64'(DDRAM_RD), 64'd1);
        chk("t2_addr", 64'(DDRAM_ADDR), 64'h0600_0002);
        chk("t2_be",   64'(DDRAM_BE), 64'hF0);
        tick;
        chk("t2_rd_drop", 64'(DDRAM_RD), 64'd0);
        chk("t2_wait_ack", 64'(cl_ack), 64'd0);
        tick; tick; tick;
        DDRAM_DOUT = 64'hDEADBEEF_12345678;
        DDRAM_DOUT_READY = 1'b1;
        tick;
        DDRAM_DOUT_READY = 1'b0;
        chk("t2_ack",   64'(cl_ack), 64'b01);
        chk("t2_rdata", 64'(cl_rdata[31:0]), 64'hDEADBEEF);
        set_cl(0, 1'b0, 1'b0, 22'h0, 32'h0);
        tick;
        chk("t2_ack_1cyc", 64'(cl_ack), 64'd0);

        // 3: both clients requesting continuously; last grant was client 0
        a0 = n_acc;
        set_cl(0, 1'b1, 1'b1, 22'h000100, 32'hA0A0A0A0);
        set_cl(1, 1'b1, 1'b1, 22'h000200, 32'hB1B1B1B1);
        got = 0;
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            tick;
            if (cl_ack != 2'b00) begin
                exp_ack = (got % 2 == 0) ? 2'b10 : 2'b01;
                chk("t3_ack", 64'(cl_ack), 64'(exp_ack));
                chk("t3_addr", 64'(DDRAM_ADDR), (got % 2 == 0) ? 64'h0600_0100 : 64'h0600_0080);
                chk("t3_be", 64'(DDRAM_BE), 64'h0F);
                got++;
                if (got == 8) cl_req = '0;
            end
        end
        chk("t3_count", 64'(got), 64'd8);
        chk("t3_cmds", 64'(n_acc - a0), 64'd8);
        tick;
        chk("t3_idle", 64'(busy), 64'd0);

        // 4: waitrequest held through four ISSUE cycles
        a0 = n_acc;
        set_cl(0, 1'b1, 1'b1, 22'h000003, 32'h0BADF00D);
        DDRAM_BUSY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("t4_we",   64'(DDRAM_WE), 64'd1);
            chk("t4_addr", 64'(DDRAM_ADDR), 64'h0600_0001);
            chk("t4_be",   64'(DDRAM_BE), 64'hF0);
            chk("t4_din",  DDRAM_DIN, 64'h0BADF00D_0BADF00D);
            chk("t4_noack", 64'(cl_ack), 64'd0);
        end
        DDRAM_BUSY = 1'b0;
        tick;
        chk("t4_we_drop", 64'(DDRAM_WE), 64'd0);
        chk("t4_ack",  64'(cl_ack), 64'b01);
        chk("t4_cmds", 64'(n_acc - a0), 64'd1);
        set_cl(0, 1'b0, 1'b0, 22'h0, 32'h0);
        tick;

        // 5: reset while waiting for read data, then a late DOUT_READY
        set_cl(1, 1'b1, 1'b0, 22'h000007, 32'h0);
        tick;
        chk("t5_rd",   64'(DDRAM_RD), 64'd1);
        chk("t5_addr", 64'(DDRAM_ADDR), 64'h0600_0003);
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        set_cl(1, 1'b0, 1'b0, 22'h0, 32'h0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_rd_low", 64'(DDRAM_RD), 64'd0);
        chk("t5_noack", 64'(cl_ack), 64'd0);
        tick;
        DDRAM_DOUT = 64'h99999999_88888888;
        DDRAM_DOUT_READY = 1'b1;
        tick;
        DDRAM_DOUT_READY = 1'b0;
        chk("t5_late_ack",  64'(cl_ack), 64'd0);
        chk("t5_late_busy", 64'(busy), 64'd0);
        chk("t5_rdata_clr", 64'(cl_rdata[63:32]), 64'd0);
        set_cl(1, 1'b1, 1'b0, 22'h000006, 32'h0);
        tick;
        chk("t5b_rd",   64'(DDRAM_RD), 64'd1);
        chk("t5b_addr", 64'(DDRAM_ADDR), 64'h0600_0003);
        chk("t5b_be",   64'(DDRAM_BE), 64'h0F);
        tick;
        DDRAM_DOUT = 64'hCAFEF00D_11223344;
        DDRAM_DOUT_READY = 1'b1;
        tick;
        DDRAM_DOUT_READY = 1'b0;
        chk("t5b_ack",   64'(cl_ack), 64'b10);
        chk("t5b_rdata", 64'(cl_rdata[63:32]), 64'h11223344);
        set_cl(1, 1'b0, 1'b0, 22'h0, 32'h0);
        tick;
        chk("t5b_ack_1cyc", 64'(cl_ack), 64'd0);

`ifdef CADR_DDRAM_LINEBUF_EN
        // 6: buffer hit, invalidation by another client's write, then a miss
        set_cl(1, 1'b1, 1'b0, 22'h000010, 32'h0);
        tick;
        chk("t6_rd1", 64'(DDRAM_RD), 64'd1);
        tick;
        DDRAM_DOUT = 64'h55555555_AAAAAAAA;
        DDRAM_DOUT_READY = 1'b1;
        tick;
        DDRAM_DOUT_READY = 1'b0;
        chk("t6_ack1", 64'(cl_ack), 64'b10);
        chk("t6_rdata1", 64'(cl_rdata[63:32]), 64'hAAAAAAAA);
        set_cl(1, 1'b0, 1'b0, 22'h0, 32'h0);
        tick;
        a0 = n_acc;
        set_cl(1, 1'b1, 1'b0, 22'h000010, 32'h0);
        tick;
        chk("t6_hit_ack", 64'(cl_ack), 64'b10);
        chk("t6_hit_nord", 64'(DDRAM_RD), 64'd0);
        chk("t6_hit_rdata", 64'(cl_rdata[63:32]), 64'hAAAAAAAA);
        set_cl(1, 1'b0, 1'b0, 22'h0, 32'h0);
        tick;
        set_cl(0, 1'b1, 1'b1, 22'h000011, 32'h77777777);
        tick;
        chk("t6_wr_addr", 64'(DDRAM_ADDR), 64'h0600_0008);
        tick;
        chk("t6_wr_ack", 64'(cl_ack), 64'b01);
        set_cl(0, 1'b0, 1'b0, 22'h0, 32'h0);
        tick;
        set_cl(1, 1'b1, 1'b0, 22'h000010, 32'h0);
        tick;
        chk("t6_miss_rd", 64'(DDRAM_RD), 64'd1);
        chk("t6_cmds", 64'(n_acc - a0), 64'd1);
        tick;
        DDRAM_DOUT = 64'h77777777_13579BDF;
        DDRAM_DOUT_READY = 1'b1;
        tick;
        DDRAM_DOUT_READY = 1'b0;
        chk("t6_miss_ack", 64'(cl_ack), 64'b10);
        chk("t6_miss_rdata", 64'(cl_rdata[63:32]), 64'h13579BDF);
        set_cl(1, 1'b0, 1'b0, 22'h0, 32'h0);
        tick;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
